// File: rtl/acc_reg_n_if.sv
// acc_reg_n_if -- bundles the control/data lines of the accumulator register.
//   E    : enable (driven by the control unit)
//   Op   : 3-bit operation select
//   In   : WIDTH-bit operand word
//   Out  : WIDTH-bit registered accumulator value
//   Z,N,C,V : registered status flags
// master = control-unit side, slave = accumulator side.
// WIDTH must match the WIDTH of the attached acc_reg_n.
interface acc_reg_n_if #(
  parameter int WIDTH = 16
);
  logic             E;
  logic [2:0]       Op;
  logic [WIDTH-1:0] In;
  logic [WIDTH-1:0] Out;
  logic             Z;
  logic             N;
  logic             C;
  logic             V;

  modport master (
    output E, Op, In,
    input  Out, Z, N, C, V
  );

  modport slave (
    input  E, Op, In,
    output Out, Z, N, C, V
  );
endinterface

// File: rtl/acc_reg_n.sv
// acc_reg_n -- parametrised accumulator register with registered Z/N/C/V flags.
// On each enabled rising edge it holds, loads, or applies one ALU operation
// between its current contents and the operand word.
// Ports:
//   CLK   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset, overrides E
//   bus   : acc_reg_n_if slave (E, Op, In in; Out, Z, N, C, V out)
// Parameters:
//   WIDTH       : data width (>= 2)
//   RESET_VALUE : Out after reset
//   SATURATE    : 1 clamps signed ADD/SUB overflow, 0 wraps
module acc_reg_n #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SATURATE    = 1'b0
) (
  input logic         CLK,
  input logic         reset,
  acc_reg_n_if.slave  bus
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  // Clamp targets for signed overflow.
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] out_reg, out_next;
  logic             z_reg, z_next;
  logic             n_reg, n_next;
  logic             c_reg, c_next;
  logic             v_reg, v_next;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             a_msb, b_msb;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] clamp_val;

  // Both arithmetic results are built one bit wider so the top bit is the
  // unsigned carry (ADD) or borrow (SUB).
  assign sum_ext  = {1'b0, out_reg} + {1'b0, bus.In};
  assign diff_ext = {1'b0, out_reg} - {1'b0, bus.In};
  assign a_msb    = out_reg[WIDTH-1];
  assign b_msb    = bus.In[WIDTH-1];
  assign add_ovf  = (a_msb == b_msb) && (sum_ext[WIDTH-1] != a_msb);
  assign sub_ovf  = (a_msb != b_msb) && (diff_ext[WIDTH-1] != a_msb);
  // In both ADD and SUB overflow the true result has the sign of the old Out,
  // so that sign picks the clamp direction.
  assign clamp_val = a_msb ? SAT_NEG : SAT_POS;

  always_comb begin
    out_next = out_reg;
    z_next   = z_reg;
    n_next   = n_reg;
    c_next   = c_reg;
    v_next   = v_reg;
    if (bus.E && (bus.Op != OP_HOLD)) begin
      c_next = 1'b0;
      v_next = 1'b0;
      case (bus.Op)
        OP_LOAD: out_next = bus.In;
        OP_ADD: begin
          out_next = sum_ext[WIDTH-1:0];
          c_next   = sum_ext[WIDTH];
          v_next   = add_ovf;
          if (SATURATE && add_ovf) out_next = clamp_val;
        end
        OP_SUB: begin
          out_next = diff_ext[WIDTH-1:0];
          c_next   = diff_ext[WIDTH];
          v_next   = sub_ovf;
          if (SATURATE && sub_ovf) out_next = clamp_val;
        end
        OP_AND: out_next = out_reg & bus.In;
        OP_OR:  out_next = out_reg | bus.In;
        OP_SHL: begin
          out_next = {out_reg[WIDTH-2:0], 1'b0};
          c_next   = out_reg[WIDTH-1];
        end
        OP_SHR: begin
          out_next = {1'b0, out_reg[WIDTH-1:1]};
          c_next   = out_reg[0];
        end
        default: out_next = out_reg;
      endcase
      // Z and N follow the final, possibly clamped, result.
      z_next = (out_next == '0);
      n_next = out_next[WIDTH-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      out_reg <= RESET_VALUE;
      z_reg   <= (RESET_VALUE == '0);
      n_reg   <= RESET_VALUE[WIDTH-1];
      c_reg   <= 1'b0;
      v_reg   <= 1'b0;
    end else begin
      out_reg <= out_next;
      z_reg   <= z_next;
      n_reg   <= n_next;
      c_reg   <= c_next;
      v_reg   <= v_next;
    end
  end

  assign bus.Out = out_reg;
  assign bus.Z   = z_reg;
  assign bus.N   = n_reg;
  assign bus.C   = c_reg;
  assign bus.V   = v_reg;

endmodule

// File: tb/tb_acc_reg_n.sv
// tb_acc_reg_n -- bench for acc_reg_n. Three instances share one stimulus:
//   u0: RESET_VALUE=0,      SATURATE=0
//   u1: RESET_VALUE=0,      SATURATE=1
//   u2: RESET_VALUE=0x00AA, SATURATE=0
// An integer-arithmetic model tracks each instance and is compared every cycle;
// literal expectations at key points pin both the DUTs and the model.
module tb_acc_reg_n;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, ADD = 3'd2, SUB = 3'd3;
  localparam logic [2:0] AND_ = 3'd4, OR_ = 3'd5, SHL = 3'd6, SHR = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        e = 1'b1;
  logic [2:0]  op = LOAD;
  logic [15:0] din = 16'h1234;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  acc_reg_n_if #(.WIDTH(16)) if0 ();
  acc_reg_n_if #(.WIDTH(16)) if1 ();
  acc_reg_n_if #(.WIDTH(16)) if2 ();

  assign if0.E = e;  assign if0.Op = op;  assign if0.In = din;
  assign if1.E = e;  assign if1.Op = op;  assign if1.In = din;
  assign if2.E = e;  assign if2.Op = op;  assign if2.In = din;

  acc_reg_n #(.WIDTH(16), .RESET_VALUE(16'h0000), .SATURATE(1'b0))
    u0 (.CLK(clk), .reset(rst), .bus(if0));
  acc_reg_n #(.WIDTH(16), .RESET_VALUE(16'h0000), .SATURATE(1'b1))
    u1 (.CLK(clk), .reset(rst), .bus(if1));
  acc_reg_n #(.WIDTH(16), .RESET_VALUE(16'h00AA), .SATURATE(1'b0))
    u2 (.CLK(clk), .reset(rst), .bus(if2));

  logic [15:0] d_out [3];
  logic [3:0]  d_flg [3];   // {Z,N,C,V}
  assign d_out[0] = if0.Out;  assign d_flg[0] = {if0.Z, if0.N, if0.C, if0.V};
  assign d_out[1] = if1.Out;  assign d_flg[1] = {if1.Z, if1.N, if1.C, if1.V};
  assign d_out[2] = if2.Out;  assign d_flg[2] = {if2.Z, if2.N, if2.C, if2.V};

  // ---------------- behavioural model ----------------
  int cfg_rv  [3] = '{0, 0, 'hAA};
  int cfg_sat [3] = '{0, 1, 0};
  int m_out [3];
  int m_flg [3];   // Z*8 + N*4 + C*2 + V
  bit m_valid = 1'b0;

  function automatic int to_signed16(int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int a, b, r, s, c, v;
      a = m_out[k];
      b = int'(din);
      r = a; c = 0; v = 0;
      if (rst) begin
        m_out[k] = cfg_rv[k];
        m_flg[k] = ((cfg_rv[k] == 0) ? 8 : 0) + ((cfg_rv[k] >= 32768) ? 4 : 0);
      end else if (e && op != HOLD) begin
        case (op)
          LOAD: r = b;
          ADD: begin
            r = (a + b) % 65536;
            c = (a + b > 65535) ? 1 : 0;
            s = to_signed16(a) + to_signed16(b);
            v = (s > 32767 || s < -32768) ? 1 : 0;
            if (cfg_sat[k] != 0 && v != 0) r = (s > 0) ? 32767 : 32768;
          end
          SUB: begin
            r = (a - b + 65536) % 65536;
            c = (a < b) ? 1 : 0;
            s = to_signed16(a) - to_signed16(b);
            v = (s > 32767 || s < -32768) ? 1 : 0;
            if (cfg_sat[k] != 0 && v != 0) r = (s > 0) ? 32767 : 32768;
          end
          AND_: r = a & b;
          OR_:  r = a | b;
          SHL: begin r = (a * 2) % 65536; c = (a >= 32768) ? 1 : 0; end
          default: begin r = a / 2; c = a % 2; end
        endcase
        m_out[k] = r;
        m_flg[k] = ((r == 0) ? 8 : 0) + ((r >= 32768) ? 4 : 0) + c * 2 + v;
      end
    end
    m_valid = 1'b1;
  end

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("cyc_u%0d_out", k), int'(d_out[k]), m_out[k]);
        chk($sformatf("cyc_u%0d_flg", k), int'(d_flg[k]), m_flg[k]);
      end
    end
  end

  // Literal expectation: pins DUT and model on the same hand-computed value.
  task automatic lit(int k, string nm, int exp_out, int exp_flg);
    chk({nm, "_out"}, int'(d_out[k]), exp_out);
    chk({nm, "_flg"}, int'(d_flg[k]), exp_flg);
    chk({nm, "_model_out"}, m_out[k], exp_out);
    chk({nm, "_model_flg"}, m_flg[k], exp_flg);
    $display("[TB] u%0d %s: Out=%h ZNCV=%b", k, nm, d_out[k], d_flg[k]);
  endtask

  task automatic step(bit ie, logic [2:0] iop, logic [15:0] iin);
    e = ie; op = iop; din = iin;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset held with a live LOAD on the bus.
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1, LOAD, 16'h1234);
      lit(0, "reset", 'h0000, 'b1000);
      lit(2, "reset_rv", 'h00AA, 'b0000);
    end
    rst = 1'b0;

    // Enable gating and mid-cycle operand change.
    step(0, LOAD, 16'h0001);
    step(0, LOAD, 16'h0001);
    lit(0, "en_low", 'h0000, 'b1000);
    step(1, LOAD, 16'h0001);
    lit(0, "load1", 'h0001, 'b0000);
    #2 din = 16'h0002;
    #2 lit(0, "mid_cycle", 'h0001, 'b0000);
    @(negedge clk);
    lit(0, "load2", 'h0002, 'b0000);

    // Signed overflow on ADD, then HOLD and E=0 keep everything.
    step(1, LOAD, 16'h7FFF);
    step(1, ADD, 16'h0001);
    lit(0, "add_ovf", 'h8000, 'b0101);
    lit(1, "sat_add", 'h7FFF, 'b0001);
    step(1, HOLD, 16'h1111);
    lit(0, "hold", 'h8000, 'b0101);
    step(0, ADD, 16'h0001);
    lit(0, "e0_hold", 'h8000, 'b0101);

    // Unsigned carry out.
    step(1, LOAD, 16'hFFFF);
    step(1, ADD, 16'h0001);
    lit(0, "add_carry", 'h0000, 'b1010);
    lit(1, "add_carry_sat", 'h0000, 'b1010);

    // Borrow.
    step(1, LOAD, 16'h0003);
    step(1, SUB, 16'h0005);
    lit(0, "sub_borrow", 'hFFFE, 'b0110);

    // Negative overflow on SUB.
    step(1, LOAD, 16'h8000);
    step(1, SUB, 16'h0001);
    lit(0, "sub_ovf_wrap", 'h7FFF, 'b0001);
    lit(1, "sat_sub", 'h8000, 'b0101);

    // Shifts.
    step(1, LOAD, 16'h8001);
    step(1, SHL, 16'hFFFF);
    lit(0, "shl", 'h0002, 'b0010);
    step(1, SHR, 16'hFFFF);
    lit(0, "shr1", 'h0001, 'b0000);
    step(1, SHR, 16'hFFFF);
    lit(0, "shr2", 'h0000, 'b1010);

    // Logic ops.
    step(1, LOAD, 16'h00F0);
    step(1, AND_, 16'h0F0F);
    lit(0, "and", 'h0000, 'b1000);
    step(1, OR_, 16'h0A00);
    lit(0, "or", 'h0A00, 'b0000);

    // Non-zero reset value, first op after release, reset mid-chain.
    rst = 1'b1;
    step(1, LOAD, 16'h5555);
    lit(2, "rv_reset", 'h00AA, 'b0000);
    rst = 1'b0;
    step(1, ADD, 16'h0001);
    lit(2, "rv_first_op", 'h00AB, 'b0000);
    lit(0, "zero_rv_first_op", 'h0001, 'b0000);
    step(1, ADD, 16'h0001);
    lit(2, "rv_chain", 'h00AC, 'b0000);
    rst = 1'b1;
    step(1, ADD, 16'h0001);
    lit(2, "rv_reset_mid", 'h00AA, 'b0000);
    rst = 1'b0;
    step(1, ADD, 16'h0001);
    lit(2, "rv_after_release", 'h00AB, 'b0000);

    // Mixed chain left to the per-cycle model compare.
    step(1, LOAD, 16'h4000);
    step(1, ADD, 16'h4000);
    step(1, SUB, 16'h7FFF);
    step(1, SHL, 16'h0000);
    step(1, OR_, 16'h8001);
    step(1, SHR, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/acc_reg_n.md
# acc_reg_n

Parametrised accumulator register that supersedes the fixed 16-bit enable register in the accumulator datapath. On each enabled clock edge it holds, loads, or applies a single ALU-style operation between its own contents and the input word. It keeps registered status flags (Z, N, C, V) alongside the value. It sits at the accumulator slot of the datapath, driven by control-unit enable and opcode lines.

## Interface
Parameters:
- WIDTH, 16, data width in bits; legal range 2 or more.
- RESET_VALUE, 0, value loaded into Out on reset; WIDTH bits.
- SATURATE, 0, when 1 signed ADD/SUB overflow clamps the result; when 0 it wraps.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset; takes priority over E.
- E  in  1  enable; when 0, all state holds regardless of Op and In.
- Op  in  3  operation select, sampled only when E=1.
- In  in  WIDTH  operand word.
- Out  out  WIDTH  registered accumulator value.
- Z  out  1  registered zero flag.
- N  out  1  registered negative flag (MSB of Out).
- C  out  1  registered carry/borrow/shift-out flag.
- V  out  1  registered signed-overflow flag.

## Operation
- Reset (reset=1 at a rising edge):
  - Out=RESET_VALUE, C=0, V=0.
  - Z=1 if RESET_VALUE==0, else 0.
  - N=RESET_VALUE[WIDTH-1].
- E=0 with reset=0: Out, Z, N, C and V all hold.
- Op encoding with E=1 (R = new Out):
  - 000 HOLD: nothing changes, including flags.
  - 001 LOAD: R=In; C=0, V=0.
  - 010 ADD: R=Out+In, computed to WIDTH+1 bits. C=carry out of the MSB. V=1 when both operands have the same sign and the result sign differs.
  - 011 SUB: R=Out−In. C=1 on borrow (Out<In unsigned). V=1 when the operand signs differ and the result sign differs from Out.
  - 100 AND: R=Out&In; C=0, V=0.
  - 101 OR: R=Out|In; C=0, V=0.
  - 110 SHL: R=Out<<1 with LSB=0; C=old Out[WIDTH-1]; V=0. In is ignored.
  - 111 SHR: logical shift, R=Out>>1 with MSB=0; C=old Out[0]; V=0. In is ignored.
- For every non-HOLD op: Z=(R==0), N=R[WIDTH-1], both computed from the final (possibly saturated) R.
- SATURATE=1, ADD/SUB only, when V=1:
  - Positive overflow: R=0 followed by all 1s (0x7FFF at WIDTH 16).
  - Negative overflow: R=1 followed by all 0s (0x8000 at WIDTH 16).
  - V stays 1; C keeps its unsigned meaning, taken from the unclamped result.
- SATURATE=0: results wrap modulo 2^WIDTH.
- Arithmetic is unsigned for C and two's-complement for V, N and saturation. There is no carry-in.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge k appear on Out and the flags after edge k and stay stable until the next enabled edge.
- No combinational path from In, Op or E to any output. All outputs come straight from flops.
- Changing In mid-cycle, with no clock edge, has no effect on outputs.
- reset and E both high: reset wins.
- reset released: the first edge with reset=0 and E=1 performs the op against RESET_VALUE.
- Reset asserted in the middle of an operation sequence clears state at the next edge. No pending state survives.
- Consecutive enabled ops chain back-to-back, one per cycle, each using the previous cycle's Out.

## Test plan
(WIDTH=16, RESET_VALUE=0, SATURATE=0 unless stated.)
- Reset held for 5 cycles with E=1, Op=LOAD, In=0x1234 -> Out=0x0000, Z=1, N=0, C=0, V=0 throughout.
- E=0, Op=LOAD, In=0x0001 for 2 cycles -> Out stays 0x0000. Then E=1 -> Out=0x0001 after the next edge only. A mid-cycle change of In to 0x0002 -> Out stays 0x0001 until the following edge.
- ADD and SUB flags:
  - LOAD 0x7FFF, ADD 0x0001 -> Out=0x8000, V=1, N=1, C=0.
  - LOAD 0xFFFF, ADD 0x0001 -> Out=0x0000, C=1, Z=1, V=0.
  - LOAD 0x0003, SUB 0x0005 -> Out=0xFFFE, C=1, N=1.
- SATURATE=1:
  - LOAD 0x7FFF, ADD 0x0001 -> Out=0x7FFF, V=1.
  - LOAD 0x8000, SUB 0x0001 -> Out=0x8000, V=1, N=1.
- Shift and logic ops:
  - LOAD 0x8001, SHL -> Out=0x0002, C=1; SHR -> Out=0x0001, C=0; SHR -> Out=0x0000, C=1, Z=1.
  - LOAD 0x00F0, AND 0x0F0F -> Out=0x0000, Z=1.
  - OR 0x0A00 -> Out=0x0A00.
- RESET_VALUE=0x00AA: after reset, Out=0x00AA, Z=0. Asserting reset with E=1 during an ADD chain -> Out returns to 0x00AA at the next edge. HOLD preserves flags set by the previous op.
